// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// op encodings (func3), FSM state enum and an op signedness helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } md_sign_t;

  // Operand signedness per op; MUL is treated as signed since the low half
  // of the product does not depend on it.
  function automatic md_sign_t md_op_sign(input md_op_e op);
    md_sign_t s;
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: s = '{a_signed: 1'b1, b_signed: 1'b1};
      MD_MULHSU:                       s = '{a_signed: 1'b1, b_signed: 1'b0};
      default:                         s = '{a_signed: 1'b0, b_signed: 1'b0};
    endcase
    return s;
  endfunction

  // Upper func3 bit separates the divide family from the multiply family.
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave), including flush and the busy stall.
interface muldiv_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration over the {hi,lo} accumulator: right-shifting shift-add for
// multiply, left-shifting restoring shift-subtract for divide.
module muldiv_step #(
  parameter int DATA_W = 64
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  // Multiply adds the multiplicand when the multiplier LSB is set; divide
  // brings the next dividend bit into the partial remainder. The remainder
  // is always below the divisor, so the subtraction fits in DATA_W bits.
  assign sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
  assign shifted = {hi_i, lo_i[DATA_W-1]};
  assign diff    = shifted[DATA_W-1:0] - opnd_i;

  // Choose the multiply or divide update of the accumulator.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div) begin
      if (shifted >= {1'b0, opnd_i}) begin
        hi_o = diff;
        lo_o = {lo_i[DATA_W-2:0], 1'b1};
      end else begin
        hi_o = shifted[DATA_W-1:0];
        lo_o = {lo_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[DATA_W:1];
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit beside the EX-stage ALU.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies are computed in one
// combinational step in PREP and skip CALC; divides are unaffected.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  md_sign_t            sgn;
  logic                is_div;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                b_zero, div_ovf;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0]   quo_s, rem_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
`endif

  // Operand magnitudes, sign flags and the special-case detectors used in PREP.
  always_comb begin
    sgn     = md_op_sign(op_q);
    is_div  = md_is_div(op_q);
    a_neg   = sgn.a_signed & a_q[DATA_W-1];
    b_neg   = sgn.b_signed & b_q[DATA_W-1];
    mag_a   = a_neg ? -a_q : a_q;
    mag_b   = b_neg ? -b_q : b_q;
    b_zero  = (b_q == '0);
    div_ovf = ((op_q == MD_DIV) || (op_q == MD_REM)) && (a_q == MIN_INT) && (b_q == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`endif

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div (is_div),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Sign correction of the unsigned CALC result: the product and quotient
  // follow the operand sign difference, the remainder follows the dividend.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_res_q ? -prod : prod;
    quo_s  = neg_res_q ? -lo_q : lo_q;
    rem_s  = neg_rem_q ? -hi_q : hi_q;
  end

  // Next-state and datapath update; flush overrides everything but reset.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d    = md_op_e'(bus.in_op);
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          tag_d   = bus.in_tag;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        hi_d      = '0;
        lo_d      = mag_a;
        opnd_d    = mag_b;
        cnt_d     = CNT_W'(DATA_W - 1);
        if (is_div && b_zero) begin
          result_d = ((op_q == MD_DIV) || (op_q == MD_DIVU)) ? '1 : a_q;
          state_d  = DONE;
        end else if (div_ovf) begin
          result_d = (op_q == MD_DIV) ? MIN_INT : '0;
          state_d  = DONE;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          if (!is_div) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = FIX;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        case (op_q)
          MD_MUL:                       result_d = prod_s[DATA_W-1:0];
          MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_s[2*DATA_W-1:DATA_W];
          MD_DIV, MD_DIVU:              result_d = quo_s;
          default:                      result_d = rem_s;
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // A result is never presented in the cycle it is being flushed.
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == DONE) && !bus.flush;
    bus.out_result = result_q;
    bus.out_tag    = tag_q;
    bus.busy       = (state_q != IDLE);
  end

endmodule
